// File: rtl/sm4_key_expansion_if.sv
// Master-key load and round-key read bus of the SM4 key schedule.
// The key schedule is the slave; the loader/round datapath is the master.
interface sm4_key_expansion_if #(
  parameter int word_width_p = 32,
  parameter int group_size_p = 128
);
  logic                    mkey_v_i;
  logic [group_size_p-1:0] mkey_i;
  logic                    ready_o;
  logic [4:0]              rkey_addr_i;
  logic [word_width_p-1:0] rkey_o;
  logic                    keys_valid_o;
  logic                    done_o;

  modport slave (
    input  mkey_v_i, mkey_i, rkey_addr_i,
    output ready_o, rkey_o, keys_valid_o, done_o
  );

  modport master (
    output mkey_v_i, mkey_i, rkey_addr_i,
    input  ready_o, rkey_o, keys_valid_o, done_o
  );
endinterface

// File: rtl/sm4_key_expansion.sv
// Iterative SM4 key schedule: one round key per cycle into a 32-entry
// register file with a combinational read port.

// SM4 byte substitution, purely combinational.
module sbox_memory (
  input  logic [7:0] i_addr,
  output logic [7:0] o_data
);
  localparam logic [0:255][7:0] c_sbox = {
    128'hD690E9FECCE13DB716B614C228FB2C05,
    128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62,
    128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8,
    128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887,
    128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1,
    128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F,
    128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8,
    128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684,
    128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };

  assign o_data = c_sbox[i_addr];
endmodule

module sm4_key_expansion #(
  parameter int word_width_p = 32,
  parameter int group_size_p = 128,
  parameter int rounds_p     = 32
) (
  input logic                clk_i,
  input logic                reset_i,
  sm4_key_expansion_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [127:0] c_fk = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_last;
  logic [4:0]              r_cnt;
  logic [7:0]              r_ck_base;
  logic                    r_done;
  logic [word_width_p-1:0] r_k  [4];
  logic [word_width_p-1:0] r_rk [rounds_p];
  logic [31:0]             w_ck;
  logic [31:0]             w_tmp;
  logic [31:0]             w_b;
  logic [31:0]             w_l;
  logic [31:0]             w_rk_new;

  // Next-state decode: accept a key whenever not expanding, finish on the last round.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    w_state_next = r_state;
    w_ready      = 1'b1;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.mkey_v_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_ready = 1'b0;
        if (r_cnt == 5'(rounds_p - 1)) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Round function: CK bytes are base, base+7, base+14, base+21 (mod 256).
  assign w_ck  = {r_ck_base, r_ck_base + 8'd7, r_ck_base + 8'd14, r_ck_base + 8'd21};
  assign w_tmp = r_k[1] ^ r_k[2] ^ r_k[3] ^ w_ck;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox_memory u_sbox (
      .i_addr (w_tmp[31-8*g -: 8]),
      .o_data (w_b[31-8*g -: 8])
    );
  end

  // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23).
  assign w_l      = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
  assign w_rk_new = r_k[0] ^ w_l;

  // Working key window, round counter, CK accumulator and completion pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt     <= '0;
      r_ck_base <= '0;
      r_done    <= 1'b0;
      for (int j = 0; j < 4; j++) r_k[j] <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        for (int j = 0; j < 4; j++)
          r_k[j] <= bus.mkey_i[group_size_p-1-32*j -: 32] ^ c_fk[127-32*j -: 32];
        r_cnt     <= '0;
        r_ck_base <= '0;
      end else if (r_state == ST_EXPAND) begin
        r_k[0]    <= r_k[1];
        r_k[1]    <= r_k[2];
        r_k[2]    <= r_k[3];
        r_k[3]    <= w_rk_new;
        r_cnt     <= r_cnt + 5'd1;
        r_ck_base <= r_ck_base + 8'd28;
      end
    end
  end

  // Round-key register file, one entry written per expansion cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: this storage is reset on purpose so a freshly reset block reads back all-zero keys.
    if (reset_i) begin
      for (int i = 0; i < rounds_p; i++) r_rk[i] <= '0;
    end else if (r_state == ST_EXPAND && !w_accept) begin
      r_rk[r_cnt] <= w_rk_new;
    end
  end

  assign bus.ready_o      = w_ready;
  assign bus.keys_valid_o = (r_state == ST_DONE);
  assign bus.done_o       = r_done;
  assign bus.rkey_o       = r_rk[bus.rkey_addr_i];
endmodule

// File: tb/tb_sm4_key_expansion.sv
// Self-checking bench for sm4_key_expansion: textbook SM4 key-schedule model,
// per-cycle compare of handshake outputs and read port, plus literal vectors.
module tb_sm4_key_expansion;
  logic clk     = 1'b0;
  logic reset_i = 1'b0;
  bit   cmp_en  = 1'b0;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] c_std = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] c_alt = 128'hDEADBEEF00112233445566778899AABB;

  sm4_key_expansion_if bus ();

  sm4_key_expansion dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (textbook SM4 key schedule) ----------------
  logic [0:255][7:0] sb = {
    128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sb[a[31:24]], sb[a[23:16]], sb[a[15:8]], sb[a[7:0]]};
  endfunction

  function automatic logic [31:0] ck_word(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
    return w;
  endfunction

  function automatic logic [0:31][31:0] expand(input logic [127:0] mk);
    logic [31:0]       k [36];
    logic [0:31][31:0] rk;
    logic [127:0]      fk;
    logic [31:0]       b;
    fk = 128'hA3B1BAC656AA3350677D9197B27022DC;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      b        = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i));
      k[i+4]   = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      rk[i]    = k[i+4];
    end
    return rk;
  endfunction

  // Cycle model: a busy countdown of 32 rounds after each accepted key.
  int                m_left  = 0;
  bit                m_valid = 1'b0;
  bit                m_done  = 1'b0;
  bit                m_known = 1'b1;
  logic [0:31][31:0] m_rk    = '0;
  logic [0:31][31:0] m_pend  = '0;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_known <= 1'b1;
      m_rk    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done  <= 1'b1;
          m_valid <= 1'b1;
          m_known <= 1'b1;
          m_rk    <= m_pend;
        end
      end else if (bus.mkey_v_i) begin
        m_left  <= 32;
        m_valid <= 1'b0;
        m_known <= 1'b0;
        m_pend  <= expand(bus.mkey_i);
      end
    end
  end

  // Compare process, on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", 32'(bus.ready_o), 32'(m_left == 0));
      check("keys_valid", 32'(bus.keys_valid_o), 32'(m_valid));
      check("done", 32'(bus.done_o), 32'(m_done));
      if (m_known) check("rkey", bus.rkey_o, m_rk[bus.rkey_addr_i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] key);
    bus.mkey_v_i = 1'b1;
    bus.mkey_i   = key;
    tick();
    bus.mkey_v_i = 1'b0;
  endtask

  // Waits (bounded) for done_o; optionally probes CK and injects busy-time keys.
  task automatic wait_done(input bit probe, input bit busy, output int lat, output int low_valid);
    logic [31:0] exp_ck;
    lat       = 0;
    low_valid = 0;
    while (lat < 40 && !bus.done_o) begin
      if (probe && (lat == 0 || lat == 1 || lat == 31)) begin
        exp_ck = (lat == 0) ? 32'h00070E15 : (lat == 1) ? 32'h1C232A31 : 32'h646B7279;
        check("ck_probe", dut.w_ck, exp_ck);
      end
      if (busy) begin
        bus.mkey_v_i = (lat >= 5 && lat <= 20);
        bus.mkey_i   = c_alt;
        if (lat >= 5 && lat <= 20) check("busy_ready", 32'(bus.ready_o), 32'd0);
      end
      if (!bus.keys_valid_o) low_valid++;
      tick();
      lat++;
    end
    bus.mkey_v_i = 1'b0;
  endtask

  initial begin
    logic [0:31][31:0] exp_rk;
    int lat;
    int low;

    bus.mkey_v_i    = 1'b0;
    bus.mkey_i      = '0;
    bus.rkey_addr_i = '0;

    // Reset and reset-state checks.
    #1 reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    cmp_en = 1'b1;
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_valid", 32'(bus.keys_valid_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.rkey_addr_i = 5'(a);
      #1 check("rst_rkey", bus.rkey_o, 32'd0);
      tick();
    end

    // Pin the model to published values.
    exp_rk = expand(c_std);
    check("model_rk0", exp_rk[0], 32'hF12186F9);
    check("model_rk1", exp_rk[1], 32'h41662B61);
    check("model_rk31", exp_rk[31], 32'h9124A012);
    check("model_ck0", ck_word(0), 32'h00070E15);
    check("model_ck31", ck_word(31), 32'h646B7279);

    // Standard vector with CK probes.
    load(c_std);
    wait_done(1'b1, 1'b0, lat, low);
    check("std_latency", 32'(lat), 32'd32);
    bus.rkey_addr_i = 5'd0;  #1 check("std_rk0", bus.rkey_o, 32'hF12186F9);
    bus.rkey_addr_i = 5'd1;  #1 check("std_rk1", bus.rkey_o, 32'h41662B61);
    bus.rkey_addr_i = 5'd31; #1 check("std_rk31", bus.rkey_o, 32'h9124A012);
    tick();

    // Busy behaviour: a different key offered during rounds 5..20 is ignored.
    load(c_std);
    wait_done(1'b0, 1'b1, lat, low);
    check("busy_latency", 32'(lat), 32'd32);
    bus.rkey_addr_i = 5'd31; #1 check("busy_rk31", bus.rkey_o, 32'h9124A012);
    check("dc_valid", 32'(bus.keys_valid_o), 32'd1);

    // Back-to-back: MK=0 accepted in the first DONE cycle.
    load('0);
    wait_done(1'b0, 1'b0, lat, low);
    check("b2b_latency", 32'(lat), 32'd32);
    check("b2b_low_valid", 32'(low), 32'd32);
    exp_rk = expand('0);
    for (int a = 0; a < 32; a++) begin
      bus.rkey_addr_i = 5'(a);
      #1 check("b2b_rk", bus.rkey_o, exp_rk[a]);
    end
    tick();

    // Reset during expansion cycle 10.
    load(c_std);
    repeat (10) tick();
    #1 reset_i = 1'b1;
    bus.rkey_addr_i = 5'd0;
    #1;
    check("mid_rst_ready", 32'(bus.ready_o), 32'd1);
    check("mid_rst_valid", 32'(bus.keys_valid_o), 32'd0);
    check("mid_rst_done", 32'(bus.done_o), 32'd0);
    check("mid_rst_rkey0", bus.rkey_o, 32'd0);
    tick();
    reset_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.rkey_addr_i = 5'(a);
      tick();
    end
    load(c_std);
    wait_done(1'b0, 1'b0, lat, low);
    check("post_rst_latency", 32'(lat), 32'd32);
    bus.rkey_addr_i = 5'd31; #1 check("post_rst_rk31", bus.rkey_o, 32'h9124A012);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm4_key_expansion.md
# sm4_key_expansion

Iterative SM4 key schedule. Accepts a 128-bit master key, derives the 32 round keys rk0..rk31 at one round per cycle, and holds them in an internal register file. The round-transform datapath reads them one 32-bit word per round through a combinational read port.

## Interface

Parameters:
- word_width_p, 32, round-key word width (fixed by the sm4_encryptor package).
- group_size_p, 128, master-key width (fixed by the sm4_encryptor package).
- rounds_p, 32, number of round keys.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- mkey_v_i  input  1  master key valid.
- mkey_i  input  group_size_p  master key, MK0 in bits [127:96].
- ready_o  output  1  block can accept a master key.
- rkey_addr_i  input  5  round-key read index.
- rkey_o  output  word_width_p  rk[rkey_addr_i], combinational read.
- keys_valid_o  output  1  all 32 round keys of the last accepted key are stored.
- done_o  output  1  one-cycle pulse when expansion completes.

## Operation

- FSM states:
  - IDLE: ready_o=1.
  - EXPAND: ready_o=0.
  - DONE: ready_o=1, keys_valid_o=1.
- Transitions:
  - IDLE, with mkey_v_i & ready_o: go to EXPAND. Load K[0..3] = MK[0..3] ^ FK, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC. Clear round counter cnt to 0. Clear keys_valid_o.
  - EXPAND, each cycle: tmp = K1 ^ K2 ^ K3 ^ CK(cnt). Apply four byte S-boxes (sbox_memory instances) to get B. Compute L'(B) = B ^ (B<<<13) ^ (B<<<23). Set rk_new = K0 ^ L'(B). Write rk[cnt] = rk_new. Shift K to {K1,K2,K3,rk_new}. Increment cnt.
  - EXPAND with cnt==31: the write happens, then go to DONE. Assert done_o for exactly that transition cycle (registered, high in the first DONE cycle).
  - DONE, with mkey_v_i: same action as IDLE acceptance. keys_valid_o drops the next cycle; old rk contents are overwritten progressively.
- CK generation: byte j of CK(i) is (4i+j)*7 mod 256, with byte 0 at bits [31:24]. Generate from an 8-bit accumulator base that steps by 28 per round. Bytes are base, base+7, base+14, base+21, all mod 256. No ROM.
- mkey_v_i in EXPAND is ignored (not accepted, not queued).
- Read port: rkey_o = rk[rkey_addr_i] at all times, including during EXPAND, where it returns stale or partially updated contents. Consumers gate on keys_valid_o.
- Decrypt ordering (rk31 first) is the consumer's job, done by driving rkey_addr_i = 31 - round.

## Timing

- Reset values:
  - State IDLE, ready_o=1, keys_valid_o=0, done_o=0.
  - cnt=0, CK accumulator base=0, K registers 0.
  - All 32 rk entries 0, so rkey_o=0.
- Accept at edge E0. rk[i] is written at edge E0+1+i. rk31 is written at E0+32.
- keys_valid_o and done_o go high after E0+32, so the latency is 32 cycles from acceptance.
- done_o is high for one cycle only.
- Back-to-back: a key accepted in the first DONE cycle restarts expansion. keys_valid_o is high for exactly one cycle, and ready_o is low for the next 32 cycles.
- Reset asserted mid-EXPAND: everything returns immediately (asynchronously) to reset values. No partial keys are reported valid afterward.
- Critical path: 3-input XOR, S-box, L', XOR. One round per cycle, no pipelining.

## Test plan

- Reset check: after reset, ready_o=1, keys_valid_o=0, done_o=0, and rkey_o=0 for all addresses 0..31.
- Standard vector: MK = 0123456789ABCDEFFEDCBA9876543210.
  - done_o pulses exactly 32 cycles after acceptance.
  - rk[0]=F12186F9, rk[1]=41662B61, rk[31]=9124A012.
- CK check: probe internal CK for cnt 0, 1, 31. Expect 00070E15, 1C232A31, 646B7279.
- Busy behaviour: pulse mkey_v_i with a different key during EXPAND cycles 5..20. The key is ignored, ready_o stays 0, and final rk[31] still equals 9124A012.
- Back-to-back: in the first DONE cycle, present MK=0. keys_valid_o is high for one cycle, then low for 32 cycles. Final rk values match the software model for MK=0.
- Reset mid-operation: assert reset_i at expansion cycle 10. Outputs return to reset values at once. A subsequent standard-vector load completes correctly with 32-cycle latency.
